// File: rtl/axi_sysid_pkg.sv
// Shared constants for the system-ID ROM access path: region selects,
// legal ROM read latency range and default ROM geometry.
package axi_sysid_pkg;

  localparam logic [1:0] SYSID_REGION_SYS = 2'h1;
  localparam logic [1:0] SYSID_REGION_PR  = 2'h2;

  localparam int ROM_LATENCY_MIN   = 1;
  localparam int ROM_LATENCY_MAX   = 4;
  localparam int ROM_WIDTH_DEF     = 32;
  localparam int ROM_ADDR_BITS_DEF = 9;

  // Wide enough to hold ROM_LATENCY_MAX-1.
  localparam int LAT_CNT_W = $clog2(ROM_LATENCY_MAX);

endpackage

// File: rtl/sysid_rr_arb2.sv
// Two-input round-robin grant. On a tie the port that did not win last time
// is granted; last_grant only moves when update_en is high and a grant is given.
module sysid_rr_arb2
  import axi_sysid_pkg::*;
(
  input  logic       up_clk,
  input  logic       up_rstn,
  input  logic [1:0] req,
  input  logic       update_en,
  output logic [1:0] gnt
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase

    last_grant_d = last_grant_q;
    if (update_en && (gnt != 2'b00)) begin
      last_grant_d = gnt[1];
    end
  end

  // Reset to 1 so port 0 wins the first contention.
  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/sysid_rom_arbiter.sv
// Shares one synchronous system-ID ROM read port between two requesters,
// one access in flight at a time, fixed ROM read latency.
//
// state  | meaning
// IDLE   | ready offered to the granted port; accept latches rom_addr
// ISSUE  | rom_addr stable, latency counter loaded
// WAIT   | counting down; rom_data captured when counter hits 0
// RESP   | owner's rsp_valid high for this one cycle
module sysid_rom_arbiter
  import axi_sysid_pkg::*;
#(
  parameter int ROM_WIDTH     = ROM_WIDTH_DEF,
  parameter int ROM_ADDR_BITS = ROM_ADDR_BITS_DEF,
  parameter int ROM_LATENCY   = 1
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic                     req0_valid,
  input  logic [ROM_ADDR_BITS-1:0] req0_addr,
  output logic                     req0_ready,
  output logic                     rsp0_valid,
  output logic [ROM_WIDTH-1:0]     rsp0_data,
  input  logic                     req1_valid,
  input  logic [ROM_ADDR_BITS-1:0] req1_addr,
  output logic                     req1_ready,
  output logic                     rsp1_valid,
  output logic [ROM_WIDTH-1:0]     rsp1_data,
  output logic [ROM_ADDR_BITS-1:0] rom_addr,
  input  logic [ROM_WIDTH-1:0]     rom_data
);

  generate
    if (ROM_LATENCY < ROM_LATENCY_MIN || ROM_LATENCY > ROM_LATENCY_MAX) begin : g_bad_latency
      $error("sysid_rom_arbiter: ROM_LATENCY must be within 1..4");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t                   state_q, state_d;
  logic [ROM_ADDR_BITS-1:0] rom_addr_q, rom_addr_d;
  logic                     owner_q, owner_d;
  logic [LAT_CNT_W-1:0]     cnt_q, cnt_d;
  logic [1:0]               rsp_valid_q, rsp_valid_d;
  logic [ROM_WIDTH-1:0]     rsp0_data_q, rsp0_data_d;
  logic [ROM_WIDTH-1:0]     rsp1_data_q, rsp1_data_d;

  logic [1:0] gnt;
  logic       idle;

  assign idle = (state_q == S_IDLE);

  sysid_rr_arb2 u_arb (
    .up_clk    (up_clk),
    .up_rstn   (up_rstn),
    .req       ({req1_valid, req0_valid}),
    .update_en (idle),
    .gnt       (gnt)
  );

  assign req0_ready = idle && gnt[0];
  assign req1_ready = idle && gnt[1];

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    owner_d     = owner_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 2'b00;
    rsp0_data_d = rsp0_data_q;
    rsp1_data_d = rsp1_data_q;

    case (state_q)
      S_IDLE: begin
        if (gnt != 2'b00) begin
          rom_addr_d = gnt[1] ? req1_addr : req0_addr;
          owner_d    = gnt[1];
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = LAT_CNT_W'(ROM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (owner_q) rsp1_data_d = rom_data;
          else         rsp0_data_d = rom_data;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = S_RESP;
        end else begin
          cnt_d = cnt_q - LAT_CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge up_clk or negedge up_rstn) begin
    if (!up_rstn) begin
      state_q     <= S_IDLE;
      rom_addr_q  <= '0;
      owner_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= 2'b00;
      rsp0_data_q <= '0;
      rsp1_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      owner_q     <= owner_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp0_data_q <= rsp0_data_d;
      rsp1_data_q <= rsp1_data_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;

endmodule

// File: tb/tb_sysid_rom_arbiter.sv
// Directed bench for sysid_rom_arbiter: one instance at ROM latency 1 and one
// at latency 4, each fed by a ROM model that returns X until the address is stable.
module tb_sysid_rom_arbiter;

  logic up_clk = 1'b0;
  logic up_rstn = 1'b0;
  always #5 up_clk = ~up_clk;

  logic        req0_valid, req1_valid, req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [8:0]  req0_addr, req1_addr, rom_addr;
  logic [31:0] rsp0_data, rsp1_data, rom_data;

  logic        b_req0_valid, b_req0_ready, b_req1_ready, b_rsp0_valid, b_rsp1_valid;
  logic [8:0]  b_req0_addr, b_rom_addr;
  logic [31:0] b_rsp0_data, b_rsp1_data, b_rom_data;

  int total = 0;
  int bad = 0;

  sysid_rom_arbiter #(.ROM_WIDTH(32), .ROM_ADDR_BITS(9), .ROM_LATENCY(1)) dut_a (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
    .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data),
    .rom_addr(rom_addr), .rom_data(rom_data)
  );

  sysid_rom_arbiter #(.ROM_WIDTH(32), .ROM_ADDR_BITS(9), .ROM_LATENCY(4)) dut_b (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_ready(b_req0_ready),
    .rsp0_valid(b_rsp0_valid), .rsp0_data(b_rsp0_data),
    .req1_valid(1'b0), .req1_addr(9'h000), .req1_ready(b_req1_ready),
    .rsp1_valid(b_rsp1_valid), .rsp1_data(b_rsp1_data),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data)
  );

  function automatic logic [31:0] rom_fn(input logic [8:0] a);
    if (a == 9'h005) return 32'h53594944;
    return {7'h55, a, 7'h2A, a};
  endfunction

  // ROM models: data valid only once the address has been stable for LATENCY cycles.
  logic [8:0] ha;
  logic [8:0] hb [4];
  always @(posedge up_clk) begin
    ha    <= rom_addr;
    hb[0] <= b_rom_addr;
    hb[1] <= hb[0];
    hb[2] <= hb[1];
    hb[3] <= hb[2];
  end
  always_comb rom_data = (ha === rom_addr) ? rom_fn(rom_addr) : 'x;
  always_comb b_rom_data = (hb[0] === b_rom_addr && hb[1] === b_rom_addr &&
                            hb[2] === b_rom_addr && hb[3] === b_rom_addr)
                           ? rom_fn(b_rom_addr) : 'x;

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge up_clk);
    #1;
  endtask

  always @(negedge up_clk) begin
    if (up_rstn && (rsp0_valid || rsp1_valid))
      chk_b("rsp_exclusive", rsp0_valid & rsp1_valid, 1'b0);
  end

  initial begin
    int g, last, acc, p0, p1, n;
    logic took;

    req0_valid = 1'b0; req0_addr = 9'h000;
    req1_valid = 1'b0; req1_addr = 9'h000;
    b_req0_valid = 1'b0; b_req0_addr = 9'h000;
    up_rstn = 1'b0;
    repeat (2) @(posedge up_clk);
    #1;
    chk_w("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk_b("rst_rsp0_valid", rsp0_valid, 1'b0);
    chk_b("rst_rsp1_valid", rsp1_valid, 1'b0);
    chk_w("rst_rsp0_data", rsp0_data, 32'h0);
    chk_w("rst_rsp1_data", rsp1_data, 32'h0);
    chk_b("rst_ready0_idle", req0_ready, 1'b0);
    up_rstn = 1'b1;
    tick;

    // Contention from reset: port 0 first, then alternating.
    req0_valid = 1'b1; req0_addr = 9'h010;
    req1_valid = 1'b1; req1_addr = 9'h011;
    g = 0; last = 0;
    for (int c = 0; c < 24 && g < 4; c++) begin
      #1;
      if (c == 0) chk_b("arb_first_port0", req0_ready, 1'b1);
      if (req0_ready || req1_ready) begin
        chk_b("arb_grant_order", req1_ready, (g % 2) == 1);
        chk_b("arb_onehot", req0_ready & req1_ready, 1'b0);
        if (g > 0) chk_w("arb_spacing", 32'(c - last), 32'd4);
        last = c;
        g++;
      end
      tick;
    end
    chk_w("arb_accepts", 32'(g), 32'd4);
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick; tick;
    chk_b("arb_last_rsp1_valid", rsp1_valid, 1'b1);
    chk_w("arb_rsp1_data", rsp1_data, rom_fn(9'h011));
    chk_w("arb_rsp0_data", rsp0_data, rom_fn(9'h010));
    tick;

    // Single port-0 read of address 5.
    req0_valid = 1'b1; req0_addr = 9'h005;
    #1;
    chk_b("t1_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    chk_w("t1_rom_addr", 32'(rom_addr), 32'h005);
    chk_b("t1_rsp_t1", rsp0_valid, 1'b0);
    tick;
    chk_b("t1_rsp_t2", rsp0_valid, 1'b0);
    tick;
    chk_b("t1_rsp_t3", rsp0_valid, 1'b1);
    chk_w("t1_rsp_data", rsp0_data, 32'h53594944);
    tick;
    chk_b("t1_rsp_t4", rsp0_valid, 1'b0);

    // Four back-to-back port-1 requests.
    req1_valid = 1'b1; req1_addr = 9'h020;
    acc = 0; p0 = 0; p1 = 0; last = 0;
    for (int c = 0; c < 20; c++) begin
      if (rsp1_valid) begin
        chk_w("bb_rsp1_data", rsp1_data, rom_fn(9'(32'h20 + p1)));
        p1++;
      end
      if (rsp0_valid) p0++;
      #1;
      took = 1'b0;
      if (req1_valid && req1_ready) begin
        if (acc > 0) chk_w("bb_spacing", 32'(c - last), 32'd4);
        last = c;
        acc++;
        took = 1'b1;
      end
      tick;
      if (took) begin
        if (acc == 4) req1_valid = 1'b0;
        else req1_addr = 9'(32'h20 + acc);
      end
    end
    chk_w("bb_accepts", 32'(acc), 32'd4);
    chk_w("bb_rsp1_pulses", 32'(p1), 32'd4);
    chk_w("bb_rsp0_pulses", 32'(p0), 32'd0);
    chk_w("bb_rsp0_data_held", rsp0_data, 32'h53594944);

    // Port 1 requests while port 0 is busy, then withdraws before IDLE.
    req0_valid = 1'b1; req0_addr = 9'h030;
    #1;
    chk_b("drop_ready0", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_addr = 9'h031;
    #1;
    chk_b("drop_busy_t1", req1_ready, 1'b0);
    tick;
    #1;
    chk_b("drop_busy_t2", req1_ready, 1'b0);
    tick;
    req1_valid = 1'b0;
    chk_b("drop_rsp0_valid", rsp0_valid, 1'b1);
    chk_w("drop_rsp0_data", rsp0_data, rom_fn(9'h030));
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (rsp1_valid) n++;
    end
    chk_w("drop_no_rsp1", 32'(n), 32'd0);
    chk_w("drop_rsp1_data_held", rsp1_data, rom_fn(9'h023));
    chk_w("drop_rom_addr_held", 32'(rom_addr), 32'h030);

    // Reset while in WAIT.
    req0_valid = 1'b1; req0_addr = 9'h040;
    #1;
    chk_b("rstw_ready0", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    tick;
    up_rstn = 1'b0;
    #1;
    chk_w("rstw_rom_addr", 32'(rom_addr), 32'h0);
    chk_w("rstw_rsp0_data", rsp0_data, 32'h0);
    chk_w("rstw_rsp1_data", rsp1_data, 32'h0);
    chk_b("rstw_rsp0_valid", rsp0_valid, 1'b0);
    tick;
    up_rstn = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (rsp0_valid || rsp1_valid) n++;
    end
    chk_w("rstw_no_rsp", 32'(n), 32'd0);
    req0_valid = 1'b1; req0_addr = 9'h044;
    #1;
    chk_b("rstw_next_ready", req0_ready, 1'b1);
    tick;
    req0_valid = 1'b0;
    tick; tick;
    chk_b("rstw_next_valid", rsp0_valid, 1'b1);
    chk_w("rstw_next_data", rsp0_data, rom_fn(9'h044));

    // Latency-4 instance, top address.
    b_req0_valid = 1'b1; b_req0_addr = 9'h1FF;
    #1;
    chk_b("lat4_ready", b_req0_ready, 1'b1);
    tick;
    b_req0_valid = 1'b0;
    chk_w("lat4_rom_addr", 32'(b_rom_addr), 32'h1FF);
    for (int k = 1; k <= 6; k++) begin
      chk_b("lat4_valid_timing", b_rsp0_valid, k == 6);
      if (k == 5) chk_w("lat4_data_not_early", b_rsp0_data, 32'h0);
      if (k < 6) tick;
    end
    chk_w("lat4_data", b_rsp0_data, rom_fn(9'h1FF));
    chk_b("lat4_rsp1_valid", b_rsp1_valid, 1'b0);
    chk_b("lat4_req1_ready", b_req1_ready, 1'b0);
    chk_w("lat4_rsp1_data", b_rsp1_data, 32'h0);
    tick;
    chk_b("lat4_valid_one_cycle", b_rsp0_valid, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
